// File: rtl/uart_rx_framed.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_framed
// Description : 8-bit UART receiver with mid-bit sampling, frame/parity error
//               flags and break handling. Optional parity bit when the macro
//               UART_RX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_framed #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rx,
  input  logic       parity_sel,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t c_after_data = PARITY;
`else
  localparam state_t c_after_data = STOP;
`endif

  state_t           r_state;
  state_t           w_state_next;
  logic             r_rx_meta;
  logic             r_rx_s;
  logic             r_rx_prev;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             w_tick;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // The start bit is checked at half a bit time; every later sample lands mid-bit.
  always_comb begin
    w_state_next = r_state;
    w_tick = (r_state == START) ? (r_baud_cnt == c_half_last)
                                : (r_baud_cnt == c_bit_last);
    case (r_state)
      IDLE:      if (r_rx_prev && !r_rx_s) w_state_next = START;
      START:     if (w_tick) w_state_next = r_rx_s ? IDLE : DATA;
      DATA:      if (w_tick && (r_bit_cnt == 3'd7)) w_state_next = c_after_data;
      PARITY:    if (w_tick) w_state_next = STOP;
      STOP:      if (w_tick) w_state_next = r_rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (r_rx_s) w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= 3'd0;
    end else begin
      if ((r_state == IDLE) || (r_state == WAIT_IDLE) || w_tick)
        r_baud_cnt <= '0;
      else
        r_baud_cnt <= r_baud_cnt + 1'b1;

      if (r_state == IDLE)
        r_bit_cnt <= 3'd0;
      else if ((r_state == DATA) && w_tick)
        r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_shift   <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if ((r_state == DATA) && w_tick)
        r_shift <= {r_rx_s, r_shift[7:1]};
      if ((r_state == STOP) && w_tick) begin
        rx_data   <= r_shift;
        frame_err <= ~r_rx_s;
        rx_valid  <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_sel;
  logic r_par_bit;

  // Parity mode is latched at start detect so mid-frame changes are ignored.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_par_sel  <= 1'b0;
      r_par_bit  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if ((r_state == IDLE) && (w_state_next == START))
        r_par_sel <= parity_sel;
      if ((r_state == PARITY) && w_tick)
        r_par_bit <= r_rx_s;
      if ((r_state == STOP) && w_tick)
        parity_err <= ((^r_shift) ^ r_par_bit) != r_par_sel;
    end
  end
`else
  logic w_unused_parity_sel;
  assign w_unused_parity_sel = parity_sel;
  assign parity_err          = 1'b0;
`endif

endmodule
`default_nettype wire
